// File: rtl/arbitro_mem_dados_if.sv
// Bundle of the two requester ports (CPU and debug/loader) and the
// single-port data memory bus served by arbitro_mem_dados.
//
// Handshake (same for both requesters): req is a level. Once req rises,
// the requester holds esc/end/dado stable until its ack is high. ack is a
// single-cycle pulse. In the cycle after ack, the requester either drops
// req or keeps it high with new fields to start another access. saida is
// valid from the ack cycle of a read and holds until the next read by that
// port. The memory returns mem_saida one cycle after it sees mem_end.
interface arbitro_mem_dados_if #(
  parameter int LARG_DADO = 32,
  parameter int LARG_END  = 8
);
  logic                 req_cpu;
  logic                 esc_cpu;
  logic [LARG_END-1:0]  end_cpu;
  logic [LARG_DADO-1:0] dado_cpu;
  logic                 ack_cpu;
  logic [LARG_DADO-1:0] saida_cpu;
  logic                 parada_cpu;

  logic                 req_dbg;
  logic                 esc_dbg;
  logic [LARG_END-1:0]  end_dbg;
  logic [LARG_DADO-1:0] dado_dbg;
  logic                 ack_dbg;
  logic [LARG_DADO-1:0] saida_dbg;

  logic [LARG_END-1:0]  mem_end;
  logic [LARG_DADO-1:0] mem_entr;
  logic                 mem_hab_esc;
  logic [LARG_DADO-1:0] mem_saida;

  // Arbiter side.
  modport slave (
    input  req_cpu, esc_cpu, end_cpu, dado_cpu,
    input  req_dbg, esc_dbg, end_dbg, dado_dbg,
    input  mem_saida,
    output ack_cpu, saida_cpu, parada_cpu,
    output ack_dbg, saida_dbg,
    output mem_end, mem_entr, mem_hab_esc
  );

  // Requesters plus memory side.
  modport master (
    output req_cpu, esc_cpu, end_cpu, dado_cpu,
    output req_dbg, esc_dbg, end_dbg, dado_dbg,
    output mem_saida,
    input  ack_cpu, saida_cpu, parada_cpu,
    input  ack_dbg, saida_dbg,
    input  mem_end, mem_entr, mem_hab_esc
  );
endinterface

// File: rtl/arbitro_mem_dados.sv
// Arbiter/sequencer for the single-port data memory shared by the CPU
// load/store path and the debug/loader port. One access at a time:
// OCIOSO (arbitrate) -> ACESSO (address/write) -> [CAPTURA (read data)]
// -> CONFIRMA (ack). The CPU wins ties for up to MAX_CPU consecutive
// grants while the debug port waits; then debug is served.
// estado exposes the FSM state (0 OCIOSO, 1 ACESSO, 2 CAPTURA, 3 CONFIRMA).
module arbitro_mem_dados #(
  parameter int LARG_DADO = 32,
  parameter int LARG_END  = 8,
  parameter int MAX_CPU   = 4
) (
  input  logic                clk,
  input  logic                rst,
  arbitro_mem_dados_if.slave  bus,
  output logic [1:0]          estado
);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    ACESSO   = 2'd1,
    CAPTURA  = 2'd2,
    CONFIRMA = 2'd3
  } estado_t;

  localparam int LARG_CONT = $clog2(MAX_CPU + 1);
  localparam logic [LARG_CONT-1:0] MAX_CONT = LARG_CONT'(MAX_CPU);
  localparam logic [LARG_CONT-1:0] UM_CONT  = LARG_CONT'(1);

  // dono: 0 = CPU owns the current access, 1 = debug port.
  estado_t              estado_q, estado_d;
  logic                 dono_q, dono_d;
  logic [LARG_CONT-1:0] cont_q, cont_d;
  logic                 ack_cpu_q, ack_cpu_d;
  logic                 ack_dbg_q, ack_dbg_d;
  logic [LARG_DADO-1:0] saida_cpu_q, saida_cpu_d;
  logic [LARG_DADO-1:0] saida_dbg_q, saida_dbg_d;
  logic [LARG_END-1:0]  mem_end_q, mem_end_d;
  logic [LARG_DADO-1:0] mem_entr_q, mem_entr_d;
  logic                 hab_q, hab_d;

  logic grant_cpu;
  logic grant_dbg;

  // CPU wins unless debug is waiting and the CPU has used its quota.
  assign grant_cpu = bus.req_cpu & (~bus.req_dbg | (cont_q < MAX_CONT));
  assign grant_dbg = bus.req_dbg & ~grant_cpu;

  // Next-state and next-register logic for the access sequencer.
  always_comb begin
    estado_d    = estado_q;
    dono_d      = dono_q;
    cont_d      = cont_q;
    ack_cpu_d   = 1'b0;
    ack_dbg_d   = 1'b0;
    saida_cpu_d = saida_cpu_q;
    saida_dbg_d = saida_dbg_q;
    mem_end_d   = mem_end_q;
    mem_entr_d  = mem_entr_q;
    hab_d       = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (grant_cpu) begin
          dono_d     = 1'b0;
          mem_end_d  = bus.end_cpu;
          mem_entr_d = bus.dado_cpu;
          hab_d      = bus.esc_cpu;
          estado_d   = ACESSO;
          // Count only grants that made the debug port wait.
          if (bus.req_dbg && (cont_q != MAX_CONT)) begin
            cont_d = cont_q + UM_CONT;
          end
        end else if (grant_dbg) begin
          dono_d     = 1'b1;
          mem_end_d  = bus.end_dbg;
          mem_entr_d = bus.dado_dbg;
          hab_d      = bus.esc_dbg;
          estado_d   = ACESSO;
          cont_d     = '0;
        end
      end
      ACESSO: begin
        // hab_q still holds the latched esc of the owner.
        if (hab_q) begin
          ack_cpu_d = ~dono_q;
          ack_dbg_d = dono_q;
          estado_d  = CONFIRMA;
        end else begin
          estado_d  = CAPTURA;
        end
      end
      CAPTURA: begin
        if (dono_q) begin
          saida_dbg_d = bus.mem_saida;
        end else begin
          saida_cpu_d = bus.mem_saida;
        end
        ack_cpu_d = ~dono_q;
        ack_dbg_d = dono_q;
        estado_d  = CONFIRMA;
      end
      CONFIRMA: begin
        // Requests are not looked at in the ack cycle.
        estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q    <= OCIOSO;
      dono_q      <= 1'b0;
      cont_q      <= '0;
      ack_cpu_q   <= 1'b0;
      ack_dbg_q   <= 1'b0;
      saida_cpu_q <= '0;
      saida_dbg_q <= '0;
      mem_end_q   <= '0;
      mem_entr_q  <= '0;
      hab_q       <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      dono_q      <= dono_d;
      cont_q      <= cont_d;
      ack_cpu_q   <= ack_cpu_d;
      ack_dbg_q   <= ack_dbg_d;
      saida_cpu_q <= saida_cpu_d;
      saida_dbg_q <= saida_dbg_d;
      mem_end_q   <= mem_end_d;
      mem_entr_q  <= mem_entr_d;
      hab_q       <= hab_d;
    end
  end

  assign bus.ack_cpu     = ack_cpu_q;
  assign bus.ack_dbg     = ack_dbg_q;
  assign bus.saida_cpu   = saida_cpu_q;
  assign bus.saida_dbg   = saida_dbg_q;
  assign bus.mem_end     = mem_end_q;
  assign bus.mem_entr    = mem_entr_q;
  assign bus.mem_hab_esc = hab_q;
  // Stall the PC while a CPU access is pending, released in its ack cycle.
  assign bus.parada_cpu  = bus.req_cpu & ~ack_cpu_q;
  assign estado          = estado_q;

endmodule

// File: tb/tb_arbitro_mem_dados.sv
// Testbench for arbitro_mem_dados: directed CPU/debug traffic against a
// behavioural single-port memory, with ordered expected-ack and
// expected-write queues checked by a negedge monitor.
module tb_arbitro_mem_dados;

  localparam int LD = 32;
  localparam int LE = 8;
  localparam int WA = 2 * LD + 1;   // {port, saida_cpu, saida_dbg}
  localparam int WW = LE + LD;      // {mem_end, mem_entr}

  localparam logic [1:0] EST_OCIOSO  = 2'd0;
  localparam logic [1:0] EST_ACESSO  = 2'd1;
  localparam logic [1:0] EST_CAPTURA = 2'd2;

  logic       clk;
  logic       rst;
  logic [1:0] estado;

  arbitro_mem_dados_if #(.LARG_DADO(LD), .LARG_END(LE)) bus ();

  arbitro_mem_dados #(.LARG_DADO(LD), .LARG_END(LE), .MAX_CPU(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .estado (estado)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory model ----------------
  logic [LD-1:0] mem [0:255];

  always @(posedge clk) begin
    if (bus.mem_hab_esc) mem[bus.mem_end] <= bus.mem_entr;
    bus.mem_saida <= mem[bus.mem_end];
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [WA-1:0] exp_q[$];
  logic [WW-1:0] exp_wr_q[$];
  logic [LD-1:0] m_saida_cpu = '0;
  logic [LD-1:0] m_saida_dbg = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_ack(input logic port, input logic rd, input logic [LD-1:0] data);
    if (rd) begin
      if (port) m_saida_dbg = data;
      else      m_saida_cpu = data;
    end
    exp_q.push_back({port, m_saida_cpu, m_saida_dbg});
  endtask

  task automatic push_wr(input logic [LE-1:0] a, input logic [LD-1:0] d);
    exp_wr_q.push_back({a, d});
  endtask

  // Monitor: pops one expected entry per ack / memory write cycle.
  always @(negedge clk) begin
    logic [WA-1:0] e;
    logic [WW-1:0] w;
    chk("parada_cpu", bus.parada_cpu, bus.req_cpu & ~bus.ack_cpu);
    if (bus.ack_cpu && bus.ack_dbg) begin
      n_checks++;
      n_errors++;
      $display("FAIL ack_overlap: got both acks high, required at most one");
    end
    if (bus.mem_hab_esc) begin
      chk("hab_esc_state", estado, EST_ACESSO);
      if (exp_wr_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got write end=%0h dado=%0h, required none",
                 bus.mem_end, bus.mem_entr);
      end else begin
        w = exp_wr_q.pop_front();
        chk("write_end", bus.mem_end, w[WW-1:LD]);
        chk("write_dado", bus.mem_entr, w[LD-1:0]);
      end
    end
    if (bus.ack_cpu || bus.ack_dbg) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_ack: got ack_cpu=%0b ack_dbg=%0b, required none",
                 bus.ack_cpu, bus.ack_dbg);
      end else begin
        e = exp_q.pop_front();
        chk("ack_port", bus.ack_dbg, e[WA-1]);
        chk("saida_cpu", bus.saida_cpu, e[2*LD-1:LD]);
        chk("saida_dbg", bus.saida_dbg, e[LD-1:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cpu_set(input logic esc, input logic [LE-1:0] a, input logic [LD-1:0] d);
    bus.req_cpu  = 1'b1;
    bus.esc_cpu  = esc;
    bus.end_cpu  = a;
    bus.dado_cpu = d;
  endtask

  task automatic dbg_set(input logic esc, input logic [LE-1:0] a, input logic [LD-1:0] d);
    bus.req_dbg  = 1'b1;
    bus.esc_dbg  = esc;
    bus.end_dbg  = a;
    bus.dado_dbg = d;
  endtask

  // Counts rising edges until the port's ack is seen (bounded).
  task automatic wait_ack(input logic port, output int n);
    logic seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      seen = port ? bus.ack_dbg : bus.ack_cpu;
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_ack port=%0d: got no ack in %0d cycles, required one", port, n);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    rst = 1'b1;
    bus.req_cpu = 1'b0; bus.esc_cpu = 1'b0; bus.end_cpu = '0; bus.dado_cpu = '0;
    bus.req_dbg = 1'b0; bus.esc_dbg = 1'b0; bus.end_dbg = '0; bus.dado_dbg = '0;
    repeat (3) next_cycle();
    chk("rst_estado", estado, EST_OCIOSO);
    chk("rst_ack_cpu", bus.ack_cpu, 1'b0);
    chk("rst_ack_dbg", bus.ack_dbg, 1'b0);
    chk("rst_hab", bus.mem_hab_esc, 1'b0);
    chk("rst_saida_cpu", bus.saida_cpu, '0);
    chk("rst_saida_dbg", bus.saida_dbg, '0);
    rst = 1'b0;
    next_cycle();

    // Test 1: reset during a CPU write in ACESSO.
    push_wr(8'h20, 32'h1111_1111);
    cpu_set(1'b1, 8'h20, 32'h1111_1111);
    next_cycle();
    chk("t1_hab_acesso", bus.mem_hab_esc, 1'b1);
    chk("t1_estado_acesso", estado, EST_ACESSO);
    rst = 1'b1;
    bus.req_cpu = 1'b0;
    next_cycle();
    chk("t1_hab_rst", bus.mem_hab_esc, 1'b0);
    chk("t1_ack_rst", bus.ack_cpu, 1'b0);
    chk("t1_estado_rst", estado, EST_OCIOSO);
    chk("t1_mem_end_rst", bus.mem_end, '0);
    chk("t1_mem_entr_rst", bus.mem_entr, '0);
    next_cycle();
    chk("t1_ack_rst2", bus.ack_cpu, 1'b0);
    chk("t1_estado_rst2", estado, EST_OCIOSO);
    rst = 1'b0;
    next_cycle();

    // Test 2: CPU write 0x10 <- DEADBEEF, cycle-exact timing.
    push_wr(8'h10, 32'hDEAD_BEEF);
    push_ack(1'b0, 1'b0, '0);
    cpu_set(1'b1, 8'h10, 32'hDEAD_BEEF);
    #1;
    chk("t2_parada_t0", bus.parada_cpu, 1'b1);
    next_cycle();
    chk("t2_hab_t1", bus.mem_hab_esc, 1'b1);
    chk("t2_end_t1", bus.mem_end, 8'h10);
    chk("t2_entr_t1", bus.mem_entr, 32'hDEAD_BEEF);
    chk("t2_parada_t1", bus.parada_cpu, 1'b1);
    chk("t2_ack_t1", bus.ack_cpu, 1'b0);
    next_cycle();
    chk("t2_ack_t2", bus.ack_cpu, 1'b1);
    chk("t2_hab_t2", bus.mem_hab_esc, 1'b0);
    chk("t2_parada_t2", bus.parada_cpu, 1'b0);
    next_cycle();
    bus.req_cpu = 1'b0;
    chk("t2_ack_t3", bus.ack_cpu, 1'b0);
    next_cycle();

    // Test 3: debug read of 0x10.
    push_ack(1'b1, 1'b1, 32'hDEAD_BEEF);
    dbg_set(1'b0, 8'h10, '0);
    wait_ack(1'b1, n);
    chk("t3_lat_read", n, 3);
    next_cycle();
    bus.req_dbg = 1'b0;
    repeat (2) next_cycle();
    chk("t3_saida_dbg_held", bus.saida_dbg, 32'hDEAD_BEEF);
    chk("t3_saida_cpu_same", bus.saida_cpu, '0);

    // Test 4: both ports held; order C,C,C,C,D,C,C,C,C,D.
    for (int i = 0; i < 4; i++) begin
      push_wr(8'h40 + 8'(i), 32'hC0DE_0000 + 32'(i));
      push_ack(1'b0, 1'b0, '0);
    end
    push_ack(1'b1, 1'b1, 32'hC0DE_0000);
    for (int i = 4; i < 8; i++) begin
      push_wr(8'h40 + 8'(i), 32'hC0DE_0000 + 32'(i));
      push_ack(1'b0, 1'b0, '0);
    end
    push_ack(1'b1, 1'b1, 32'hC0DE_0004);
    fork
      begin
        int nc;
        for (int i = 0; i < 8; i++) begin
          if (i > 0) next_cycle();
          cpu_set(1'b1, 8'h40 + 8'(i), 32'hC0DE_0000 + 32'(i));
          wait_ack(1'b0, nc);
          chk("t4_cpu_lat", nc, (i == 4) ? 6 : 2);
        end
        next_cycle();
        bus.req_cpu = 1'b0;
      end
      begin
        int nd;
        dbg_set(1'b0, 8'h40, '0);
        wait_ack(1'b1, nd);
        chk("t4_dbg_lat1", nd, 15);
        next_cycle();
        dbg_set(1'b0, 8'h44, '0);
        wait_ack(1'b1, nd);
        chk("t4_dbg_lat2", nd, 15);
        next_cycle();
        bus.req_dbg = 1'b0;
      end
    join
    repeat (2) next_cycle();

    // Test 5: debug request raised while CPU read is in CAPTURA.
    push_ack(1'b0, 1'b1, 32'hC0DE_0003);
    push_wr(8'h50, 32'hA5A5_A5A5);
    push_ack(1'b1, 1'b0, '0);
    fork
      begin
        int nc;
        cpu_set(1'b0, 8'h43, '0);
        wait_ack(1'b0, nc);
        chk("t5_cpu_lat", nc, 3);
        next_cycle();
        bus.req_cpu = 1'b0;
      end
      begin
        int nd;
        repeat (2) next_cycle();
        chk("t5_estado_captura", estado, EST_CAPTURA);
        dbg_set(1'b1, 8'h50, 32'hA5A5_A5A5);
        wait_ack(1'b1, nd);
        chk("t5_dbg_lat", nd, 4);
        next_cycle();
        bus.req_dbg = 1'b0;
      end
    join
    repeat (2) next_cycle();

    // Test 6: one-cycle CPU pulse while debug owns the memory.
    push_ack(1'b1, 1'b1, 32'hA5A5_A5A5);
    fork
      begin
        int nd;
        dbg_set(1'b0, 8'h50, '0);
        wait_ack(1'b1, nd);
        chk("t6_dbg_lat", nd, 3);
        next_cycle();
        bus.req_dbg = 1'b0;
      end
      begin
        next_cycle();
        chk("t6_estado_acesso", estado, EST_ACESSO);
        cpu_set(1'b1, 8'h60, 32'h6666_6666);
        #1;
        chk("t6_parada_hi", bus.parada_cpu, 1'b1);
        next_cycle();
        bus.req_cpu = 1'b0;
        #1;
        chk("t6_parada_lo", bus.parada_cpu, 1'b0);
      end
    join
    repeat (6) next_cycle();

    chk("end_ack_queue_empty", exp_q.size(), 0);
    chk("end_wr_queue_empty", exp_wr_q.size(), 0);
    chk("end_estado", estado, EST_OCIOSO);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
